// File: rtl/fsm_sequenciador_param.sv
// Parametrised master sequencer for the bottling line: walks N_ETAPAS slave stages,
// handles CQ reject, cork-alarm pause, graceful stop and dozen counting.
// Optional watchdog / ERRO state is built only when the macro TIMEOUT_EN is defined.
module fsm_sequenciador_param #(
  parameter int N_ETAPAS = 6,
  parameter int ETAPA_CQ = 4,
  parameter logic [N_ETAPAS-1:0] ALARME_MASK = 6'b101101,
  parameter int TIMEOUT_CICLOS = 50000000,
  parameter int TIMEOUT_W = 26,
  parameter int GARRAFAS_POR_DUZIA = 12,
  localparam int IW = $clog2(N_ETAPAS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                parar,
  input  logic                alarme_rolha,
  input  logic                sensor_final,
  input  logic [N_ETAPAS-1:0] etapa_concluida,
  input  logic                garrafa_aprovada,
  output logic [N_ETAPAS-1:0] cmd_etapa,
  output logic [IW-1:0]       etapa_atual,
  output logic [2:0]          estado_dbg,
  output logic                ocupado,
  output logic                garrafa_descartada,
  output logic                garrafa_contada,
  output logic                incrementar_duzia,
  output logic                erro_timeout
);

  localparam int CW = (GARRAFAS_POR_DUZIA > 1) ? $clog2(GARRAFAS_POR_DUZIA) : 1;
  localparam logic [IW-1:0] ULTIMA = IW'(N_ETAPAS - 1);
  localparam logic [IW-1:0] IDX_CQ = IW'(ETAPA_CQ);
  localparam logic [CW-1:0] CONT_MAX = CW'(GARRAFAS_POR_DUZIA - 1);
  localparam logic [N_ETAPAS-1:0] UM = N_ETAPAS'(1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    EMITE          = 3'd1,
    AGUARDA        = 3'd2,
    CONTANDO_FINAL = 3'd3,
    PAUSADO        = 3'd4,
    ERRO           = 3'd5
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [IW-1:0] etapa_q, etapa_d;
  logic [CW-1:0] cont_q, cont_d;
  logic          pend_q, pend_d;
  logic          sensor_prev_q;
  logic          descarta_d, contada_d, duzia_d;

`ifdef TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LIMITE = TIMEOUT_W'(TIMEOUT_CICLOS - 1);
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
`endif

  assign etapa_atual = etapa_q;

  always_comb begin
    estado_d   = estado_q;
    etapa_d    = etapa_q;
    cont_d     = cont_q;
    pend_d     = pend_q;
    descarta_d = 1'b0;
    contada_d  = 1'b0;
    duzia_d    = 1'b0;
`ifdef TIMEOUT_EN
    wd_d       = wd_q;
`endif
    if (parar && estado_q != IDLE) pend_d = 1'b1;

    case (estado_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          etapa_d  = '0;
          estado_d = alarme_rolha ? PAUSADO : EMITE;
        end
      end
      EMITE: begin
`ifdef TIMEOUT_EN
        wd_d = '0;
`endif
        estado_d = AGUARDA;
      end
      // Alarm outranks a done flag arriving in the same cycle; the stage is held.
      AGUARDA: begin
        if (alarme_rolha && ALARME_MASK[etapa_q]) begin
          estado_d = PAUSADO;
        end else if (etapa_concluida[etapa_q]) begin
          if (etapa_q == IDX_CQ && !garrafa_aprovada) begin
            descarta_d = 1'b1;
            etapa_d    = '0;
            estado_d   = pend_q ? IDLE : EMITE;
          end else if (etapa_q == ULTIMA) begin
            estado_d = CONTANDO_FINAL;
          end else begin
            etapa_d  = etapa_q + 1'b1;
            estado_d = EMITE;
          end
        end
`ifdef TIMEOUT_EN
        else if (wd_q == WD_LIMITE) begin
          estado_d = ERRO;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      CONTANDO_FINAL: begin
        if (sensor_final && !sensor_prev_q) begin
          contada_d = 1'b1;
          if (cont_q == CONT_MAX) begin
            cont_d  = '0;
            duzia_d = 1'b1;
          end else begin
            cont_d = cont_q + 1'b1;
          end
          etapa_d  = '0;
          estado_d = pend_q ? IDLE : EMITE;
        end
      end
      PAUSADO: begin
        if (!alarme_rolha) estado_d = EMITE;
      end
`ifdef TIMEOUT_EN
      ERRO: begin
        if (start) begin
          etapa_d  = '0;
          estado_d = IDLE;
        end
      end
`endif
      default: begin
        etapa_d  = '0;
        estado_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q           <= IDLE;
      etapa_q            <= '0;
      cont_q             <= '0;
      pend_q             <= 1'b0;
      sensor_prev_q      <= 1'b0;
      cmd_etapa          <= '0;
      estado_dbg         <= 3'd0;
      ocupado            <= 1'b0;
      garrafa_descartada <= 1'b0;
      garrafa_contada    <= 1'b0;
      incrementar_duzia  <= 1'b0;
`ifdef TIMEOUT_EN
      wd_q               <= '0;
      erro_timeout       <= 1'b0;
`endif
    end else begin
      estado_q           <= estado_d;
      etapa_q            <= etapa_d;
      cont_q             <= cont_d;
      pend_q             <= pend_d;
      sensor_prev_q      <= sensor_final;
      cmd_etapa          <= (estado_d == EMITE || estado_d == AGUARDA) ? (UM << etapa_d) : '0;
      estado_dbg         <= estado_d;
      ocupado            <= (estado_d != IDLE) && (estado_d != ERRO);
      garrafa_descartada <= descarta_d;
      garrafa_contada    <= contada_d;
      incrementar_duzia  <= duzia_d;
`ifdef TIMEOUT_EN
      wd_q               <= wd_d;
      erro_timeout       <= (estado_d == ERRO);
`endif
    end
  end

`ifndef TIMEOUT_EN
  assign erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_sequenciador_param.sv
// Directed bench for fsm_sequenciador_param: nominal bottle, CQ reject, alarm pause,
// timeout (TIMEOUT_EN builds), dozen pulses, graceful stop and mid-run reset.
module tb_fsm_sequenciador_param;
  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, parar, alarme_rolha, sensor_final, garrafa_aprovada;
  logic [N-1:0] etapa_concluida;
  logic [N-1:0] cmd_etapa;
  logic [2:0]   etapa_atual;
  logic [2:0]   estado_dbg;
  logic         ocupado, garrafa_descartada, garrafa_contada, incrementar_duzia, erro_timeout;

  int checks = 0;
  int passed = 0;
  int duziaSeen = 0;

  fsm_sequenciador_param #(
    .N_ETAPAS(6), .ETAPA_CQ(4), .ALARME_MASK(6'b101101),
    .TIMEOUT_CICLOS(16), .TIMEOUT_W(26), .GARRAFAS_POR_DUZIA(12)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .parar(parar),
    .alarme_rolha(alarme_rolha), .sensor_final(sensor_final),
    .etapa_concluida(etapa_concluida), .garrafa_aprovada(garrafa_aprovada),
    .cmd_etapa(cmd_etapa), .etapa_atual(etapa_atual), .estado_dbg(estado_dbg),
    .ocupado(ocupado), .garrafa_descartada(garrafa_descartada),
    .garrafa_contada(garrafa_contada), .incrementar_duzia(incrementar_duzia),
    .erro_timeout(erro_timeout)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic applyReset;
    reset = 1'b1; start = 1'b0; parar = 1'b0; alarme_rolha = 1'b0;
    sensor_final = 1'b0; etapa_concluida = '0; garrafa_aprovada = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic startLine;
    start = 1'b1; tick; start = 1'b0;
  endtask

  // Entered on the negedge where stage i is in EMITE; returns on the negedge after done[i] was taken.
  task automatic passStage(input int i, input logic aprov, input logic stop);
    logic [N-1:0] want;
    want = N'(1) << i;
    checks++; if (cmd_etapa !== want) $display("[TB] FAIL emite_cmd s%0d: got %b want %b", i, cmd_etapa, want); else passed++;
    checks++; if (estado_dbg !== 3'd1) $display("[TB] FAIL emite_state s%0d: got %0d want 1", i, estado_dbg); else passed++;
    checks++; if (etapa_atual !== 3'(i)) $display("[TB] FAIL emite_etapa s%0d: got %0d want %0d", i, etapa_atual, i); else passed++;
    parar = stop;
    tick;
    parar = 1'b0;
    checks++; if (estado_dbg !== 3'd2 || cmd_etapa !== want) $display("[TB] FAIL aguarda s%0d: got state %0d cmd %b want 2 %b", i, estado_dbg, cmd_etapa, want); else passed++;
    checks++; if ({garrafa_descartada, garrafa_contada, incrementar_duzia} !== 3'b000) $display("[TB] FAIL pulses_idle s%0d: got %b want 000", i, {garrafa_descartada, garrafa_contada, incrementar_duzia}); else passed++;
    tick; tick;
    etapa_concluida[i] = 1'b1;
    garrafa_aprovada = aprov;
    tick;
    etapa_concluida = '0;
    garrafa_aprovada = 1'b1;
  endtask

  task automatic finishBottle(input logic expDuzia, input logic expIdle);
    checks++; if (estado_dbg !== 3'd3 || cmd_etapa !== '0) $display("[TB] FAIL contando: got state %0d cmd %b want 3 000000", estado_dbg, cmd_etapa); else passed++;
    sensor_final = 1'b1;
    tick;
    sensor_final = 1'b0;
    if (incrementar_duzia === 1'b1) duziaSeen++;
    checks++; if (garrafa_contada !== 1'b1) $display("[TB] FAIL contada: got %b want 1", garrafa_contada); else passed++;
    checks++; if (incrementar_duzia !== expDuzia) $display("[TB] FAIL duzia: got %b want %b", incrementar_duzia, expDuzia); else passed++;
    checks++; if (estado_dbg !== (expIdle ? 3'd0 : 3'd1)) $display("[TB] FAIL after_bottle_state: got %0d want %0d", estado_dbg, expIdle ? 0 : 1); else passed++;
    checks++; if (etapa_atual !== 3'd0) $display("[TB] FAIL after_bottle_etapa: got %0d want 0", etapa_atual); else passed++;
  endtask

  task automatic fullBottle(input logic expDuzia, input logic expIdle);
    for (int i = 0; i < N; i++) passStage(i, 1'b1, 1'b0);
    finishBottle(expDuzia, expIdle);
  endtask

  task automatic test_reset;
    applyReset;
    checks++; if (cmd_etapa !== '0 || etapa_atual !== 3'd0 || estado_dbg !== 3'd0) $display("[TB] FAIL reset_state: got cmd %b etapa %0d state %0d want 0 0 0", cmd_etapa, etapa_atual, estado_dbg); else passed++;
    checks++; if ({ocupado, garrafa_descartada, garrafa_contada, incrementar_duzia, erro_timeout} !== 5'b0) $display("[TB] FAIL reset_flags: got %b want 00000", {ocupado, garrafa_descartada, garrafa_contada, incrementar_duzia, erro_timeout}); else passed++;
  endtask

  task automatic test_nominal;
    startLine;
    checks++; if (ocupado !== 1'b1) $display("[TB] FAIL ocupado_run: got %b want 1", ocupado); else passed++;
    fullBottle(1'b0, 1'b0);
  endtask

  task automatic test_cq_reject;
    for (int i = 0; i < 4; i++) passStage(i, 1'b1, 1'b0);
    passStage(4, 1'b0, 1'b0);
    checks++; if (garrafa_descartada !== 1'b1) $display("[TB] FAIL descartada: got %b want 1", garrafa_descartada); else passed++;
    checks++; if (garrafa_contada !== 1'b0) $display("[TB] FAIL reject_contada: got %b want 0", garrafa_contada); else passed++;
    checks++; if (estado_dbg !== 3'd1 || cmd_etapa !== 6'b000001) $display("[TB] FAIL reject_restart: got state %0d cmd %b want 1 000001", estado_dbg, cmd_etapa); else passed++;
  endtask

  task automatic test_alarm;
    passStage(0, 1'b1, 1'b0);
    tick;
    alarme_rolha = 1'b1;
    tick;
    checks++; if (estado_dbg !== 3'd2 || cmd_etapa !== 6'b000010) $display("[TB] FAIL alarm_masked: got state %0d cmd %b want 2 000010", estado_dbg, cmd_etapa); else passed++;
    tick;
    alarme_rolha = 1'b0;
    etapa_concluida[1] = 1'b1;
    tick;
    etapa_concluida = '0;
    checks++; if (estado_dbg !== 3'd1 || etapa_atual !== 3'd2) $display("[TB] FAIL alarm_masked_adv: got state %0d etapa %0d want 1 2", estado_dbg, etapa_atual); else passed++;
    passStage(2, 1'b1, 1'b0);
    tick;
    alarme_rolha = 1'b1;
    tick;
    checks++; if (estado_dbg !== 3'd4 || cmd_etapa !== '0) $display("[TB] FAIL pausado: got state %0d cmd %b want 4 000000", estado_dbg, cmd_etapa); else passed++;
    checks++; if (ocupado !== 1'b1) $display("[TB] FAIL pausado_ocupado: got %b want 1", ocupado); else passed++;
    repeat (9) tick;
    checks++; if (estado_dbg !== 3'd4) $display("[TB] FAIL pausado_hold: got %0d want 4", estado_dbg); else passed++;
    alarme_rolha = 1'b0;
    tick;
    checks++; if (estado_dbg !== 3'd1 || cmd_etapa !== 6'b001000) $display("[TB] FAIL resume: got state %0d cmd %b want 1 001000", estado_dbg, cmd_etapa); else passed++;
    for (int i = 3; i < N; i++) passStage(i, 1'b1, 1'b0);
    finishBottle(1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    passStage(0, 1'b1, 1'b0);
    passStage(1, 1'b1, 1'b0);
    repeat (16) tick;
    checks++; if (estado_dbg !== 3'd2 || erro_timeout !== 1'b0) $display("[TB] FAIL pre_timeout: got state %0d erro %b want 2 0", estado_dbg, erro_timeout); else passed++;
    tick;
`ifdef TIMEOUT_EN
    checks++; if (estado_dbg !== 3'd5 || erro_timeout !== 1'b1) $display("[TB] FAIL timeout: got state %0d erro %b want 5 1", estado_dbg, erro_timeout); else passed++;
    checks++; if (cmd_etapa !== '0 || ocupado !== 1'b0) $display("[TB] FAIL erro_outputs: got cmd %b ocupado %b want 000000 0", cmd_etapa, ocupado); else passed++;
    alarme_rolha = 1'b1;
    tick;
    alarme_rolha = 1'b0;
    checks++; if (estado_dbg !== 3'd5 || erro_timeout !== 1'b1) $display("[TB] FAIL erro_hold: got state %0d erro %b want 5 1", estado_dbg, erro_timeout); else passed++;
    startLine;
    checks++; if (estado_dbg !== 3'd0 || erro_timeout !== 1'b0) $display("[TB] FAIL erro_ack: got state %0d erro %b want 0 0", estado_dbg, erro_timeout); else passed++;
`else
    checks++; if (estado_dbg !== 3'd2 || erro_timeout !== 1'b0) $display("[TB] FAIL no_watchdog: got state %0d erro %b want 2 0", estado_dbg, erro_timeout); else passed++;
`endif
  endtask

  task automatic test_dozen;
    applyReset;
    startLine;
    duziaSeen = 0;
    for (int b = 1; b <= 24; b++) fullBottle((b % 12) == 0, 1'b0);
    checks++; if (duziaSeen !== 2) $display("[TB] FAIL duzia_count: got %0d want 2", duziaSeen); else passed++;
  endtask

  task automatic test_stop;
    passStage(0, 1'b1, 1'b0);
    passStage(1, 1'b1, 1'b0);
    passStage(2, 1'b1, 1'b1);
    for (int i = 3; i < N; i++) passStage(i, 1'b1, 1'b0);
    finishBottle(1'b0, 1'b1);
    checks++; if (ocupado !== 1'b0 || cmd_etapa !== '0) $display("[TB] FAIL stop_idle: got ocupado %b cmd %b want 0 000000", ocupado, cmd_etapa); else passed++;
    tick;
    checks++; if (estado_dbg !== 3'd0) $display("[TB] FAIL stop_hold: got %0d want 0", estado_dbg); else passed++;
  endtask

  task automatic test_back_to_back;
    startLine;
    checks++; if (estado_dbg !== 3'd1) $display("[TB] FAIL restart: got %0d want 1", estado_dbg); else passed++;
    tick;
    checks++; if (estado_dbg !== 3'd2) $display("[TB] FAIL restart_aguarda: got %0d want 2", estado_dbg); else passed++;
    reset = 1'b1;
    tick;
    checks++; if ({cmd_etapa, etapa_atual, estado_dbg} !== 12'b0 || {ocupado, garrafa_descartada, garrafa_contada, incrementar_duzia, erro_timeout} !== 5'b0) $display("[TB] FAIL midrun_reset: got cmd %b etapa %0d state %0d ocupado %b want all 0", cmd_etapa, etapa_atual, estado_dbg, ocupado); else passed++;
    reset = 1'b0;
    tick;
    checks++; if (estado_dbg !== 3'd0) $display("[TB] FAIL post_reset_idle: got %0d want 0", estado_dbg); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; parar = 1'b0; alarme_rolha = 1'b0;
    sensor_final = 1'b0; etapa_concluida = '0; garrafa_aprovada = 1'b1;
    test_reset;
    test_nominal;
    test_cq_reject;
    test_alarm;
    test_timeout;
    test_dozen;
    test_stop;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
